duhu_scoreboard: RTL

DUHU_SCOREBOARD -- requirements
Module: duhu_scoreboard

---
 rtl/duhu_pkg.sv | 19 +
 rtl/duhu_match.sv | 55 +++++
 rtl/duhu_scoreboard.sv | 82 ++++++++
 3 files changed

// File: rtl/duhu_pkg.sv
// Shared types and defaults for the duhu operand scoreboard.
package duhu_pkg;

    localparam int unsigned NSTG_DEF     = 3;
    localparam int unsigned LOAD_LAT_DEF = 1;
    localparam int unsigned RA_W_DEF     = 5;

    // Shadow entries store rd at this fixed width; RA_W must not exceed it.
    localparam int unsigned RA_W_MAX     = 8;

    localparam int unsigned FWD_RF       = 0;

    typedef struct packed {
        logic                v;
        logic [RA_W_MAX-1:0] rd;
        logic                ld;
    } shadow_t;

endpackage

// File: rtl/duhu_match.sv
// One operand's hazard check: youngest-first match over the shadow pipe,
// resolved into a forward select or a load-use / no-forward stall request.
module duhu_match
    import duhu_pkg::*;
#(
    parameter int unsigned NSTG     = NSTG_DEF,
    parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
    parameter int unsigned RA_W     = RA_W_DEF,
    parameter bit          FWD_ON   = 1'b1,
    localparam int unsigned FS_W    = $clog2(NSTG + 1)
) (
    input  shadow_t         pipe [NSTG],
    input  logic [RA_W-1:0] addr,
    input  logic            sel,
    input  logic            id_nop,
    output logic            hazard,
    output logic [FS_W-1:0] fwd
);

    logic            hit;
    logic            ld;
    logic [FS_W-1:0] stage;

    // Scan oldest to youngest so the lowest matching index wins.
    always_comb begin
        hit   = 1'b0;
        ld    = 1'b0;
        stage = '0;
        for (int unsigned i = 0; i < NSTG; i++) begin
            if (pipe[NSTG-1-i].v && (pipe[NSTG-1-i].rd == RA_W_MAX'(addr)) &&
                (addr != '0) && sel && !id_nop) begin
                hit   = 1'b1;
                ld    = pipe[NSTG-1-i].ld;
                stage = FS_W'(NSTG-1-i);
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        fwd    = FS_W'(FWD_RF);
        if (hit) begin
            if (FWD_ON) begin
                hazard = ld && (stage < FS_W'(LOAD_LAT));
                if (!hazard) begin
                    fwd = stage + FS_W'(1);
                end
            end else begin
                // WB writes through the register file, so only earlier stages stall.
                hazard = stage < FS_W'(NSTG-1);
            end
        end
    end

endmodule

// File: rtl/duhu_scoreboard.sv
// Operand scoreboard: shadow pipeline of writers after ID, per-operand forwarding
// and load-use stall. Define DUHU_FORWARD_EN to enable forwarding paths.
module duhu_scoreboard
    import duhu_pkg::*;
#(
    parameter int unsigned NSTG     = NSTG_DEF,
    parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
    parameter int unsigned RA_W     = RA_W_DEF,
    localparam int unsigned FS_W    = $clog2(NSTG + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_nop,
    input  logic            id_a_s,
    input  logic            id_b_s,
    input  logic            id_d_s,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_rf_le,
    input  logic            id_load,
    input  logic            flush,
    output logic            stall,
    output logic [FS_W-1:0] fwd_a,
    output logic [FS_W-1:0] fwd_b,
    output logic [FS_W-1:0] fwd_d,
    output logic [15:0]     stall_cnt
);

`ifdef DUHU_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    shadow_t pipe [NSTG];
    shadow_t entry0;
    logic    haz_a;
    logic    haz_b;
    logic    haz_d;

    duhu_match #(.NSTG(NSTG), .LOAD_LAT(LOAD_LAT), .RA_W(RA_W), .FWD_ON(FWD_ON)) u_match_a (
        .pipe(pipe), .addr(id_rs1), .sel(id_a_s), .id_nop(id_nop), .hazard(haz_a), .fwd(fwd_a)
    );

    duhu_match #(.NSTG(NSTG), .LOAD_LAT(LOAD_LAT), .RA_W(RA_W), .FWD_ON(FWD_ON)) u_match_b (
        .pipe(pipe), .addr(id_rs2), .sel(id_b_s), .id_nop(id_nop), .hazard(haz_b), .fwd(fwd_b)
    );

    duhu_match #(.NSTG(NSTG), .LOAD_LAT(LOAD_LAT), .RA_W(RA_W), .FWD_ON(FWD_ON)) u_match_d (
        .pipe(pipe), .addr(id_rd), .sel(id_d_s), .id_nop(id_nop), .hazard(haz_d), .fwd(fwd_d)
    );

    always_comb begin
        stall     = (haz_a | haz_b | haz_d) & ~flush;
        entry0.v  = id_rf_le & ~id_nop & ~stall & ~flush;
        entry0.rd = RA_W_MAX'(id_rd);
        entry0.ld = id_load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NSTG; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= entry0;
            for (int unsigned i = 1; i < NSTG; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
